initialization_sequencer: RTL and testbench

//  Decodes CPU writes (A0 + data) into one-cycle ICW1..ICW4 and OCW1..OCW3 strobes for the 8259A control logic.

---
 rtl/pic_8259_pkg.sv | 29 ++
 rtl/initialization_sequencer_if.sv | 20 ++
 rtl/initialization_sequencer.sv | 155 +++++++++++++++
 tb/tb_initialization_sequencer.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pic_8259_pkg.sv
// Shared 8259A definitions: initialization state encoding, command-word bit
// positions and the strobe bundle issued by the initialization sequencer.
package pic_8259_pkg;

    typedef enum logic [2:0] {
        UNINIT,
        WAIT_ICW2,
        WAIT_ICW3,
        WAIT_ICW4,
        READY
    } init_state_t;

    localparam int ICW1_IC4_BIT  = 0;
    localparam int ICW1_SNGL_BIT = 1;
    localparam int CMD_D3_BIT    = 3;
    localparam int CMD_D4_BIT    = 4;

    // One-cycle command-word write strobes; at most one field is set at a time.
    typedef struct packed {
        logic icw1;
        logic icw2;
        logic icw3;
        logic icw4;
        logic ocw1;
        logic ocw2;
        logic ocw3;
    } strobe_t;

endpackage

// File: rtl/initialization_sequencer_if.sv
// CPU write channel into the 8259A control logic: accepted-write pulse, A0 and data.
interface initialization_sequencer_if #(
    parameter int DATA_BUS_WIDTH = 8
);
    logic                      write_enable;
    logic                      address;
    logic [DATA_BUS_WIDTH-1:0] internal_data_bus;

    modport master (
        output write_enable,
        output address,
        output internal_data_bus
    );

    modport slave (
        input write_enable,
        input address,
        input internal_data_bus
    );
endinterface

// File: rtl/initialization_sequencer.sv
// 8259A initialization sequencer: decodes CPU writes into registered ICW1..ICW4 /
// OCW1..OCW3 strobes and tracks the ICW1 -> ICW2 -> [ICW3] -> [ICW4] sequence.
// Optional feature macro INIT_SEQUENCE_ERROR_EN adds a sticky sequence_error output
// flagging writes that were ignored; without it such writes are dropped silently.
module initialization_sequencer
    import pic_8259_pkg::*;
#(
    parameter int DATA_BUS_WIDTH = 8
) (
    input  logic                          clock,
    input  logic                          reset_n,
    initialization_sequencer_if.slave     cpu_wr,
    output logic [DATA_BUS_WIDTH-1:0]     registered_data_bus,
    output logic                          write_initial_command_word_1,
    output logic                          write_initial_command_word_2,
    output logic                          write_initial_command_word_3,
    output logic                          write_initial_command_word_4,
    output logic                          write_operation_control_word_1,
    output logic                          write_operation_control_word_2,
    output logic                          write_operation_control_word_3,
    output logic                          in_initialization,
`ifdef INIT_SEQUENCE_ERROR_EN
    output logic                          sequence_error,
`endif
    output logic                          single_mode_config,
    output logic                          icw4_required_config
);

    init_state_t               state_q, state_d;
    strobe_t                   strobe_q, strobe_d;
    logic [DATA_BUS_WIDTH-1:0] data_q, data_d;
    logic                      in_init_q, in_init_d;
    logic                      sngl_q, sngl_d;
    logic                      ic4_q, ic4_d;

    logic       we;
    logic       a0;
    logic       cmd_d3;
    logic       cmd_d4;

    assign we     = cpu_wr.write_enable;
    assign a0     = cpu_wr.address;
    assign cmd_d3 = cpu_wr.internal_data_bus[CMD_D3_BIT];
    assign cmd_d4 = cpu_wr.internal_data_bus[CMD_D4_BIT];

    // State, configuration latches, strobes and captured data register.
    // NOTE: every flop here uses <= so all registers update from the same pre-edge values.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= UNINIT;
            strobe_q  <= '0;
            data_q    <= '0;
            in_init_q <= 1'b0;
            sngl_q    <= 1'b0;
            ic4_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            strobe_q  <= strobe_d;
            data_q    <= data_d;
            in_init_q <= in_init_d;
            sngl_q    <= sngl_d;
            ic4_q     <= ic4_d;
        end
    end

    // Next-state: ICW1 restarts from anywhere; A0=1 writes advance the ICW sequence.
    // NOTE: every variable gets a default first so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        sngl_d  = sngl_q;
        ic4_d   = ic4_q;
        if (we) begin
            if (!a0) begin
                if (cmd_d4) begin
                    state_d = WAIT_ICW2;
                    sngl_d  = cpu_wr.internal_data_bus[ICW1_SNGL_BIT];
                    ic4_d   = cpu_wr.internal_data_bus[ICW1_IC4_BIT];
                end
            end else begin
                unique case (state_q)
                    WAIT_ICW2: begin
                        if (!sngl_q)    state_d = WAIT_ICW3;
                        else if (ic4_q) state_d = WAIT_ICW4;
                        else            state_d = READY;
                    end
                    WAIT_ICW3: state_d = ic4_q ? WAIT_ICW4 : READY;
                    WAIT_ICW4: state_d = READY;
                    default:   state_d = state_q;
                endcase
            end
        end
    end

    // Output decode: pick the single strobe for this write and capture its data.
    always_comb begin
        strobe_d  = '0;
        data_d    = data_q;
        in_init_d = (state_d == WAIT_ICW2) || (state_d == WAIT_ICW3) || (state_d == WAIT_ICW4);
        if (we) begin
            data_d = cpu_wr.internal_data_bus;
            if (!a0) begin
                if (cmd_d4)                 strobe_d.icw1 = 1'b1;
                else if (state_q == READY) begin
                    if (cmd_d3)             strobe_d.ocw3 = 1'b1;
                    else                    strobe_d.ocw2 = 1'b1;
                end
            end else begin
                unique case (state_q)
                    WAIT_ICW2: strobe_d.icw2 = 1'b1;
                    WAIT_ICW3: strobe_d.icw3 = 1'b1;
                    WAIT_ICW4: strobe_d.icw4 = 1'b1;
                    READY:     strobe_d.ocw1 = 1'b1;
                    default:   strobe_d      = '0;
                endcase
            end
        end
    end

`ifdef INIT_SEQUENCE_ERROR_EN
    logic error_q, error_d;
    logic write_ignored;

    // A write is ignored when it is a D4=0 command outside READY or an A0=1 write before ICW1.
    assign write_ignored = we && ((!a0 && !cmd_d4 && (state_q != READY)) ||
                                  (a0 && (state_q == UNINIT)));

    // Sticky error flag: ICW1 clears it, any ignored write sets it.
    always_comb begin
        error_d = error_q;
        if (strobe_d.icw1)      error_d = 1'b0;
        else if (write_ignored) error_d = 1'b1;
    end

    // Sticky error register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) error_q <= 1'b0;
        else          error_q <= error_d;
    end

    assign sequence_error = error_q;
`endif

    assign registered_data_bus            = data_q;
    assign write_initial_command_word_1   = strobe_q.icw1;
    assign write_initial_command_word_2   = strobe_q.icw2;
    assign write_initial_command_word_3   = strobe_q.icw3;
    assign write_initial_command_word_4   = strobe_q.icw4;
    assign write_operation_control_word_1 = strobe_q.ocw1;
    assign write_operation_control_word_2 = strobe_q.ocw2;
    assign write_operation_control_word_3 = strobe_q.ocw3;
    assign in_initialization              = in_init_q;
    assign single_mode_config             = sngl_q;
    assign icw4_required_config           = ic4_q;

endmodule

// File: tb/tb_initialization_sequencer.sv
// Testbench for initialization_sequencer: directed vector table, reset corner
// cases and randomized writes checked against a pending-ICW queue model.
module tb_initialization_sequencer;

    // Strobe codes: 0 none, 1..4 ICW1..ICW4, 5..7 OCW1..OCW3.
    localparam int S_NONE = 0, S_ICW1 = 1, S_ICW2 = 2, S_ICW3 = 3, S_ICW4 = 4;
    localparam int S_OCW1 = 5, S_OCW2 = 6, S_OCW3 = 7;

    logic       clock;
    logic       reset_n;
    logic [7:0] registered_data_bus;
    logic       icw1, icw2, icw3, icw4, ocw1, ocw2, ocw3;
    logic       in_initialization, single_mode_config, icw4_required_config;
`ifdef INIT_SEQUENCE_ERROR_EN
    logic       sequence_error;
`endif

    int checks = 0;
    int errors = 0;

    initialization_sequencer_if #(.DATA_BUS_WIDTH(8)) cpu_wr ();

    initialization_sequencer #(.DATA_BUS_WIDTH(8)) dut (
        .clock                          (clock),
        .reset_n                        (reset_n),
        .cpu_wr                         (cpu_wr.slave),
        .registered_data_bus            (registered_data_bus),
        .write_initial_command_word_1   (icw1),
        .write_initial_command_word_2   (icw2),
        .write_initial_command_word_3   (icw3),
        .write_initial_command_word_4   (icw4),
        .write_operation_control_word_1 (ocw1),
        .write_operation_control_word_2 (ocw2),
        .write_operation_control_word_3 (ocw3),
        .in_initialization              (in_initialization),
`ifdef INIT_SEQUENCE_ERROR_EN
        .sequence_error                 (sequence_error),
`endif
        .single_mode_config             (single_mode_config),
        .icw4_required_config           (icw4_required_config)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ---------------- reference model ----------------
    // Once ICW1 is seen the model queues the ICWs still owed; while the queue is
    // non-empty the device is initializing, afterwards it is ready for OCWs.
    bit         m_init_seen;
    int         m_pending[$];
    int         m_code;
    bit         m_sngl, m_ic4, m_err;
    logic [7:0] m_data;

    task automatic model_reset();
        m_init_seen = 1'b0;
        m_pending.delete();
        m_code = S_NONE;
        m_sngl = 1'b0;
        m_ic4  = 1'b0;
        m_err  = 1'b0;
        m_data = 8'h00;
    endtask

    task automatic model_write(input bit we, input bit a0, input logic [7:0] d);
        m_code = S_NONE;
        if (!we) return;
        m_data = d;
        if (!a0 && d[4]) begin
            m_code = S_ICW1;
            m_sngl = d[1];
            m_ic4  = d[0];
            m_init_seen = 1'b1;
            m_err = 1'b0;
            m_pending.delete();
            m_pending.push_back(S_ICW2);
            if (!m_sngl) m_pending.push_back(S_ICW3);
            if (m_ic4)   m_pending.push_back(S_ICW4);
        end else if (m_pending.size() > 0) begin
            if (a0) m_code = m_pending.pop_front();
            else    m_err  = 1'b1;
        end else if (m_init_seen) begin
            if (a0)        m_code = S_OCW1;
            else if (d[3]) m_code = S_OCW3;
            else           m_code = S_OCW2;
        end else begin
            m_err = 1'b1;
        end
    endtask

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    function automatic int strobe_count();
        return int'(icw1) + int'(icw2) + int'(icw3) + int'(icw4) +
               int'(ocw1) + int'(ocw2) + int'(ocw3);
    endfunction

    function automatic int strobe_code();
        if (icw1) return S_ICW1;
        if (icw2) return S_ICW2;
        if (icw3) return S_ICW3;
        if (icw4) return S_ICW4;
        if (ocw1) return S_OCW1;
        if (ocw2) return S_OCW2;
        if (ocw3) return S_OCW3;
        return S_NONE;
    endfunction

    task automatic compare_model(input string tag);
        check({tag, " strobe_count"}, strobe_count(), (m_code == S_NONE) ? 0 : 1);
        check({tag, " strobe"}, strobe_code(), m_code);
        check({tag, " in_init"}, int'(in_initialization), int'(m_pending.size() > 0));
        check({tag, " sngl"}, int'(single_mode_config), int'(m_sngl));
        check({tag, " ic4"}, int'(icw4_required_config), int'(m_ic4));
        if (m_code != S_NONE) check({tag, " data"}, int'(registered_data_bus), int'(m_data));
`ifdef INIT_SEQUENCE_ERROR_EN
        check({tag, " seq_err"}, int'(sequence_error), int'(m_err));
`endif
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " strobes"}, strobe_count(), 0);
        check({tag, " data"}, int'(registered_data_bus), 0);
        check({tag, " in_init"}, int'(in_initialization), 0);
        check({tag, " sngl"}, int'(single_mode_config), 0);
        check({tag, " ic4"}, int'(icw4_required_config), 0);
`ifdef INIT_SEQUENCE_ERROR_EN
        check({tag, " seq_err"}, int'(sequence_error), 0);
`endif
    endtask

    // One clock of stimulus: drive, clock edge, settle, update model, compare.
    task automatic step(input bit we, input bit a0, input logic [7:0] d, input string tag);
        cpu_wr.write_enable      = we;
        cpu_wr.address           = a0;
        cpu_wr.internal_data_bus = d;
        @(posedge clock);
        #1;
        cpu_wr.write_enable = 1'b0;
        model_write(we, a0, d);
        compare_model(tag);
    endtask

    task automatic do_reset(input string tag);
        reset_n = 1'b0;
        cpu_wr.write_enable      = 1'b0;
        cpu_wr.address           = 1'b0;
        cpu_wr.internal_data_bus = 8'h00;
        repeat (2) @(posedge clock);
        #1;
        model_reset();
        check_all_zero(tag);
        reset_n = 1'b1;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit         we;
        bit         a0;
        logic [7:0] d;
        int         exp_code;
        bit         exp_in_init;
        bit         exp_sngl;
        bit         exp_ic4;
    } vec_t;

    vec_t vecs[16];

    initial begin
        vecs = '{
            // ICW1 single + IC4, ICW2, ICW4
            '{1, 0, 8'h13, S_ICW1, 1, 1, 1},
            '{1, 1, 8'h20, S_ICW2, 1, 1, 1},
            '{1, 1, 8'h01, S_ICW4, 0, 1, 1},
            '{0, 0, 8'h00, S_NONE, 0, 1, 1},
            // ICW1 cascade, no IC4: ICW2, ICW3, ready
            '{1, 0, 8'h10, S_ICW1, 1, 0, 0},
            '{1, 1, 8'h08, S_ICW2, 1, 0, 0},
            '{1, 1, 8'h04, S_ICW3, 0, 0, 0},
            // OCWs from ready
            '{1, 1, 8'hFF, S_OCW1, 0, 0, 0},
            '{1, 0, 8'h20, S_OCW2, 0, 0, 0},
            '{1, 0, 8'h0B, S_OCW3, 0, 0, 0},
            // restart mid-sequence; a D4=0 command while waiting is ignored
            '{1, 0, 8'h11, S_ICW1, 1, 0, 1},
            '{1, 1, 8'h20, S_ICW2, 1, 0, 1},
            '{1, 0, 8'h00, S_NONE, 1, 0, 1},
            '{1, 0, 8'h12, S_ICW1, 1, 1, 0},
            '{1, 1, 8'h30, S_ICW2, 0, 1, 0},
            '{0, 0, 8'h00, S_NONE, 0, 1, 0}
        };

        reset_n = 1'b0;
        cpu_wr.write_enable      = 1'b0;
        cpu_wr.address           = 1'b0;
        cpu_wr.internal_data_bus = 8'h00;
        model_reset();

        do_reset("reset");

        foreach (vecs[i]) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            step(vecs[i].we, vecs[i].a0, vecs[i].d, tag);
            check({tag, " tbl_strobe"}, strobe_code(), vecs[i].exp_code);
            check({tag, " tbl_in_init"}, int'(in_initialization), int'(vecs[i].exp_in_init));
            check({tag, " tbl_sngl"}, int'(single_mode_config), int'(vecs[i].exp_sngl));
            check({tag, " tbl_ic4"}, int'(icw4_required_config), int'(vecs[i].exp_ic4));
            if (vecs[i].exp_code != S_NONE)
                check({tag, " tbl_data"}, int'(registered_data_bus), int'(vecs[i].d));
        end

        // Writes before any ICW1 are ignored.
        do_reset("reset2");
        step(1, 1, 8'h55, "uninit_a0_1");
        check("uninit_a0_1 none", strobe_count(), 0);
        step(1, 0, 8'h20, "uninit_ocw2");
        check("uninit_ocw2 none", strobe_count(), 0);
`ifdef INIT_SEQUENCE_ERROR_EN
        check("uninit seq_err set", int'(sequence_error), 1);
        step(1, 0, 8'h10, "icw1_clears_err");
        check("icw1 clears seq_err", int'(sequence_error), 0);
`endif

        // Reset asserted while an ICW2 strobe is in flight, heading for WAIT_ICW3.
        do_reset("reset3");
        step(1, 0, 8'h10, "r6_icw1");
        step(1, 1, 8'h08, "r6_icw2");
        check("r6 icw2 visible", int'(icw2), 1);
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        check_all_zero("async_reset");
        @(negedge clock);
        reset_n = 1'b1;
        step(1, 1, 8'h04, "after_reset_a0_1");
        check("after_reset ignored", strobe_count(), 0);

        // Randomized back-to-back traffic against the model.
        do_reset("reset4");
        for (int n = 0; n < 600; n++) begin
            bit         we;
            bit         a0;
            logic [7:0] d;
            we = ($urandom_range(0, 9) < 8);
            a0 = $urandom_range(0, 1) == 1;
            d  = 8'($urandom);
            // Keep ICW1 rarer so full sequences and ready-state OCWs are exercised.
            if (!a0 && d[4] && ($urandom_range(0, 3) != 0)) d[4] = 1'b0;
            step(we, a0, d, $sformatf("rand%0d", n));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
